// File: rtl/msrv32_pkg.sv
// ---------------------------------------------------------------------------
// msrv32_pkg
// Shared types and constants for the msrv32 data-memory path.
//   state_e        : access controller states (IDLE, BUSY, DONE, ERR)
//   LS_*           : load/store size encodings on the request bus
//   MASK_*         : canonical byte-lane write masks
//   ls_misaligned  : alignment rule for a size/offset pair
// ---------------------------------------------------------------------------
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  localparam logic [1:0] LS_BYTE = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_WORD = 2'b10;

  localparam logic [3:0] MASK_NONE    = 4'b0000;
  localparam logic [3:0] MASK_HALF_LO = 4'b0011;
  localparam logic [3:0] MASK_HALF_HI = 4'b1100;
  localparam logic [3:0] MASK_WORD    = 4'b1111;

  // Halfwords need an even address; words (size 10 and 11) need a
  // word-aligned address. Bytes are always aligned.
  function automatic logic ls_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (size == LS_HALF)
      mis = offset[0];
    else if (size != LS_BYTE)
      mis = |offset;
    return mis;
  endfunction

endpackage

// File: rtl/msrv32_store_align.sv
// ---------------------------------------------------------------------------
// msrv32_store_align
// Combinational store lane mapper.
//   size_i        in  2   access size (LS_BYTE / LS_HALF / word)
//   offset_i      in  2   byte offset within the word (addr[1:0])
//   wdata_i       in  32  right-aligned store data
//   mask_o        out 4   byte lanes to write
//   lane_data_o   out 32  store data replicated across lanes
//   misaligned_o  out 1   size/offset combination is not legal
// ---------------------------------------------------------------------------
module msrv32_store_align
  import msrv32_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] lane_data_o,
  output logic        misaligned_o
);

  always_comb begin
    mask_o       = MASK_WORD;
    lane_data_o  = wdata_i;
    misaligned_o = ls_misaligned(size_i, offset_i);
    case (size_i)
      LS_BYTE: begin
        mask_o      = 4'b0001 << offset_i;
        lane_data_o = {4{wdata_i[7:0]}};
      end
      LS_HALF: begin
        // Only addr[1] picks the half; addr[0] is caught as misaligned.
        mask_o      = offset_i[1] ? MASK_HALF_HI : MASK_HALF_LO;
        lane_data_o = {2{wdata_i[15:0]}};
      end
      default: begin
        mask_o      = MASK_WORD;
        lane_data_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// msrv32_dmem_ctrl
// Data-memory access controller: runs one load or store at a time on the
// data-memory bus, waits for dm_ack_in up to TIMEOUT BUSY cycles, stalls the
// pipeline meanwhile and hands the raw read word plus size/offset/sign
// controls to the external load unit.
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, sync active-high reset
//   req_*_in        : access request from the pipeline
//   req_ready_out   : controller idle and able to accept
//   dm_*_out        : memory request fields (registered, zero outside BUSY)
//   ms_riscv32_mp_dmdata_in, dm_ack_in : memory response
//   lu_*_out        : load-unit controls, updated only when a load completes
//   rsp_valid_out   : one-cycle completion pulse
//   stall_out       : pipeline hold
//   misaligned_out, timeout_out : one-cycle error pulses
// ---------------------------------------------------------------------------
module msrv32_dmem_ctrl
  import msrv32_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        req_valid_in,
  input  logic        req_store_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  output logic        req_ready_out,
  output logic        dm_req_out,
  output logic        dm_we_out,
  output logic [31:0] dm_addr_out,
  output logic [3:0]  dm_wr_mask_out,
  output logic [31:0] dm_wdata_out,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        dm_ack_in,
  output logic [31:0] lu_data_out,
  output logic [1:0]  lu_addr_1_to_0_out,
  output logic [1:0]  lu_size_out,
  output logic        lu_unsigned_out,
  output logic        rsp_valid_out,
  output logic        stall_out,
  output logic        misaligned_out,
  output logic        timeout_out
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        ready_q;
  logic        dm_req_q;
  logic        dm_we_q;
  logic [31:0] dm_addr_q;
  logic [3:0]  dm_mask_q;
  logic [31:0] dm_wdata_q;
  logic [1:0]  req_off_q;
  logic [1:0]  req_size_q;
  logic        req_uns_q;
  logic [31:0] lu_data_q;
  logic [1:0]  lu_off_q;
  logic [1:0]  lu_size_q;
  logic        lu_uns_q;
  logic        rsp_q;
  logic        mis_q;
  logic        to_q;

  logic [3:0]  sa_mask;
  logic [31:0] sa_data;
  logic        sa_mis;
  logic        accept_d;
  logic        last_busy_d;

  msrv32_store_align u_store_align (
    .size_i       (req_size_in),
    .offset_i     (req_addr_in[1:0]),
    .wdata_i      (req_wdata_in),
    .mask_o       (sa_mask),
    .lane_data_o  (sa_data),
    .misaligned_o (sa_mis)
  );

  // ready_q is only high in IDLE; it additionally stays low for the first
  // cycle after reset so every output reads 0 in that cycle.
  assign accept_d    = ready_q & req_valid_in;
  assign last_busy_d = (cnt_q == CNT_LAST);

  assign stall_out = ((state_q == ST_IDLE) & req_valid_in) | (state_q == ST_BUSY);

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      ready_q    <= 1'b0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'd0;
      dm_mask_q  <= MASK_NONE;
      dm_wdata_q <= 32'd0;
      req_off_q  <= 2'b00;
      req_size_q <= 2'b00;
      req_uns_q  <= 1'b0;
      lu_data_q  <= 32'd0;
      lu_off_q   <= 2'b00;
      lu_size_q  <= 2'b00;
      lu_uns_q   <= 1'b0;
      rsp_q      <= 1'b0;
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      rsp_q <= 1'b0;
      mis_q <= 1'b0;
      to_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            ready_q <= 1'b0;
            if (sa_mis) begin
              state_q <= ST_ERR;
              mis_q   <= 1'b1;
            end else begin
              state_q    <= ST_BUSY;
              cnt_q      <= 8'd0;
              dm_req_q   <= 1'b1;
              dm_we_q    <= req_store_in;
              dm_addr_q  <= {req_addr_in[31:2], 2'b00};
              dm_mask_q  <= req_store_in ? sa_mask : MASK_NONE;
              dm_wdata_q <= req_store_in ? sa_data : 32'd0;
              req_off_q  <= req_addr_in[1:0];
              req_size_q <= req_size_in;
              req_uns_q  <= req_unsigned_in;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          // An ack in the last allowed cycle is checked first, so it wins.
          if (dm_ack_in || last_busy_d) begin
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'd0;
            dm_mask_q  <= MASK_NONE;
            dm_wdata_q <= 32'd0;
          end
          if (dm_ack_in) begin
            state_q <= ST_DONE;
            rsp_q   <= 1'b1;
            if (!dm_we_q) begin
              lu_data_q <= ms_riscv32_mp_dmdata_in;
              lu_off_q  <= req_off_q;
              lu_size_q <= req_size_q;
              lu_uns_q  <= req_uns_q;
            end
          end else if (last_busy_d) begin
            state_q <= ST_ERR;
            to_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE, ST_ERR: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_out      = ready_q;
  assign dm_req_out         = dm_req_q;
  assign dm_we_out          = dm_we_q;
  assign dm_addr_out        = dm_addr_q;
  assign dm_wr_mask_out     = dm_mask_q;
  assign dm_wdata_out       = dm_wdata_q;
  assign lu_data_out        = lu_data_q;
  assign lu_addr_1_to_0_out = lu_off_q;
  assign lu_size_out        = lu_size_q;
  assign lu_unsigned_out    = lu_uns_q;
  assign rsp_valid_out      = rsp_q;
  assign misaligned_out     = mis_q;
  assign timeout_out        = to_q;

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msrv32_dmem_ctrl
// Directed bench for msrv32_dmem_ctrl with TIMEOUT=4. Inputs change 1 ns
// after the rising edge; registered outputs are read there, the
// combinational stall_out 1 ns later.
// ---------------------------------------------------------------------------
module tb_msrv32_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_uns;
  logic        req_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_mask;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic [31:0] lu_data;
  logic [1:0]  lu_off;
  logic [1:0]  lu_size;
  logic        lu_uns;
  logic        rsp;
  logic        stall;
  logic        mis;
  logic        to;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:15];
  logic [111:0] outs_v;

  assign outs_v = {req_ready, dm_req, dm_we, dm_addr, dm_mask, dm_wdata, lu_data,
                   lu_off, lu_size, lu_uns, rsp, stall, mis, to};

  msrv32_dmem_ctrl #(.TIMEOUT(4)) dut (
    .ms_riscv32_mp_clk_in    (clk),
    .ms_riscv32_mp_rst_in    (rst),
    .req_valid_in            (req_valid),
    .req_store_in            (req_store),
    .req_addr_in             (req_addr),
    .req_wdata_in            (req_wdata),
    .req_size_in             (req_size),
    .req_unsigned_in         (req_uns),
    .req_ready_out           (req_ready),
    .dm_req_out              (dm_req),
    .dm_we_out               (dm_we),
    .dm_addr_out             (dm_addr),
    .dm_wr_mask_out          (dm_mask),
    .dm_wdata_out            (dm_wdata),
    .ms_riscv32_mp_dmdata_in (dm_rdata),
    .dm_ack_in               (dm_ack),
    .lu_data_out             (lu_data),
    .lu_addr_1_to_0_out      (lu_off),
    .lu_size_out             (lu_size),
    .lu_unsigned_out         (lu_uns),
    .rsp_valid_out           (rsp),
    .stall_out               (stall),
    .misaligned_out          (mis),
    .timeout_out             (to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic store, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size,
                           input logic uns);
    req_valid = 1'b1;
    req_store = store;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_uns   = uns;
  endtask

  // Memory model: applies a store through the observed byte mask.
  task automatic mem_write;
    for (int l = 0; l < 4; l++)
      if (dm_mask[l]) mem[dm_addr[5:2]][l*8 +: 8] = dm_wdata[l*8 +: 8];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (outs_v !== 112'd0) begin
      n_fail++;
      $display("FAIL rst_outs: got %h exp 0", outs_v);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b exp 1", req_ready);
    end
  endtask

  task automatic test_byte_load;
    drive_req(1'b0, 32'h0000_1003, 32'h0, 2'b00, 1'b0);
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL bl_stall_req: got %b exp 1", stall);
    end
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({dm_req, dm_we, dm_addr, dm_mask} !== {1'b1, 1'b0, 32'h0000_1000, 4'b0000}) begin
      n_fail++;
      $display("FAIL bl_bus: got req=%b we=%b addr=%h mask=%b exp 1 0 00001000 0000",
               dm_req, dm_we, dm_addr, dm_mask);
    end
    dm_ack   = 1'b1;
    dm_rdata = 32'h80FF_1234;
    tick();
    dm_ack = 1'b0;
    n_checks++;
    if ({rsp, lu_data, lu_off, lu_size, lu_uns} !== {1'b1, 32'h80FF_1234, 2'b11, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL bl_rsp: got rsp=%b data=%h off=%b size=%b uns=%b exp 1 80ff1234 11 00 0",
               rsp, lu_data, lu_off, lu_size, lu_uns);
    end
    n_checks++;
    if ({dm_req, stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL bl_done_bus: got req=%b stall=%b exp 0 0", dm_req, stall);
    end
    tick();
    n_checks++;
    if ({rsp, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bl_after: got rsp=%b ready=%b exp 0 1", rsp, req_ready);
    end
  endtask

  task automatic test_half_store;
    int stall_cnt;
    int rsp_cnt;
    stall_cnt = 0;
    rsp_cnt   = 0;
    drive_req(1'b1, 32'h0000_2002, 32'h0000_ABCD, 2'b01, 1'b0);
    #1;
    if (stall === 1'b1) stall_cnt++;
    for (int b = 1; b <= 3; b++) begin
      tick();
      req_valid = 1'b0;
      n_checks++;
      if ({dm_req, dm_we, dm_addr, dm_mask, dm_wdata} !==
          {1'b1, 1'b1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD}) begin
        n_fail++;
        $display("FAIL hs_bus%0d: got req=%b we=%b addr=%h mask=%b wdata=%h exp 1 1 00002000 1100 abcdabcd",
                 b, dm_req, dm_we, dm_addr, dm_mask, dm_wdata);
      end
      if (b == 3) dm_ack = 1'b1;
      #1;
      if (stall === 1'b1) stall_cnt++;
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      dm_ack = 1'b0;
      #1;
      if (stall === 1'b1) stall_cnt++;
      if (rsp === 1'b1) rsp_cnt++;
    end
    n_checks++;
    if (stall_cnt != 4) begin
      n_fail++;
      $display("FAIL hs_stall_cycles: got %0d exp 4", stall_cnt);
    end
    n_checks++;
    if (rsp_cnt != 1) begin
      n_fail++;
      $display("FAIL hs_rsp_pulses: got %0d exp 1", rsp_cnt);
    end
    n_checks++;
    if (lu_data !== 32'h80FF_1234) begin
      n_fail++;
      $display("FAIL hs_lu_hold: got %h exp 80ff1234", lu_data);
    end
  endtask

  task automatic test_misaligned;
    drive_req(1'b0, 32'h0000_3001, 32'h0, 2'b10, 1'b0);
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({dm_req, mis, rsp, to} !== 4'b0100) begin
      n_fail++;
      $display("FAIL mis_pulse: got req=%b mis=%b rsp=%b to=%b exp 0 1 0 0", dm_req, mis, rsp, to);
    end
    tick();
    n_checks++;
    if ({dm_req, mis, rsp, req_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL mis_after: got req=%b mis=%b rsp=%b ready=%b exp 0 0 0 1",
               dm_req, mis, rsp, req_ready);
    end
  endtask

  task automatic test_byte_store;
    drive_req(1'b1, 32'h0000_0041, 32'h1234_5678, 2'b00, 1'b0);
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({dm_mask, dm_wdata, dm_addr} !== {4'b0010, 32'h7878_7878, 32'h0000_0040}) begin
      n_fail++;
      $display("FAIL bs_bus: got mask=%b wdata=%h addr=%h exp 0010 78787878 00000040",
               dm_mask, dm_wdata, dm_addr);
    end
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    tick();
  endtask

  task automatic test_timeout;
    int req_cnt;
    req_cnt = 0;
    drive_req(1'b0, 32'h0000_4000, 32'h0, 2'b10, 1'b0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dm_req === 1'b1 && to === 1'b0) req_cnt++;
      tick();
    end
    n_checks++;
    if (req_cnt != 4) begin
      n_fail++;
      $display("FAIL to_req_cycles: got %0d exp 4", req_cnt);
    end
    n_checks++;
    if ({dm_req, to, rsp} !== 3'b010) begin
      n_fail++;
      $display("FAIL to_pulse: got req=%b to=%b rsp=%b exp 0 1 0", dm_req, to, rsp);
    end
    tick();
    n_checks++;
    if ({to, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL to_after: got to=%b ready=%b exp 0 1", to, req_ready);
    end
    // Ack in the final allowed BUSY cycle must complete normally.
    drive_req(1'b0, 32'h0000_4004, 32'h0, 2'b10, 1'b1);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        dm_ack   = 1'b1;
        dm_rdata = 32'h5555_AAAA;
      end
      tick();
    end
    dm_ack = 1'b0;
    n_checks++;
    if ({rsp, to, lu_data, lu_uns} !== {1'b1, 1'b0, 32'h5555_AAAA, 1'b1}) begin
      n_fail++;
      $display("FAIL to_late_ack: got rsp=%b to=%b data=%h uns=%b exp 1 0 5555aaaa 1",
               rsp, to, lu_data, lu_uns);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    drive_req(1'b0, 32'h0000_6000, 32'h0, 2'b10, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++;
    if (dm_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_busy2: got req=%b exp 1", dm_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs_v !== 112'd0) begin
      n_fail++;
      $display("FAIL rm_outs: got %h exp 0", outs_v);
    end
    dm_ack   = 1'b1;
    dm_rdata = 32'hCAFE_F00D;
    tick();
    n_checks++;
    if ({req_ready, dm_req, rsp} !== 3'b100) begin
      n_fail++;
      $display("FAIL rm_ready: got ready=%b req=%b rsp=%b exp 1 0 0", req_ready, dm_req, rsp);
    end
    tick();
    dm_ack = 1'b0;
    n_checks++;
    if ({rsp, mis, to, lu_data} !== {3'b000, 32'h0}) begin
      n_fail++;
      $display("FAIL rm_late_ack: got rsp=%b mis=%b to=%b data=%h exp 0 0 0 00000000",
               rsp, mis, to, lu_data);
    end
  endtask

  task automatic test_back_to_back;
    drive_req(1'b1, 32'h0000_0024, 32'hDEAD_BEEF, 2'b10, 1'b0);
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({dm_we, dm_mask, dm_wdata} !== {1'b1, 4'b1111, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL bb_store_bus: got we=%b mask=%b wdata=%h exp 1 1111 deadbeef",
               dm_we, dm_mask, dm_wdata);
    end
    mem_write();
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    n_checks++;
    if ({rsp, req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL bb_done: got rsp=%b ready=%b exp 1 0", rsp, req_ready);
    end
    // Request presented during DONE must not be taken until the next cycle.
    drive_req(1'b0, 32'h0000_0024, 32'h0, 2'b10, 1'b1);
    tick();
    n_checks++;
    if ({dm_req, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL bb_idle: got req=%b ready=%b exp 0 1", dm_req, req_ready);
    end
    tick();
    req_valid = 1'b0;
    n_checks++;
    if ({dm_req, dm_we, dm_addr, dm_mask} !== {1'b1, 1'b0, 32'h0000_0024, 4'b0000}) begin
      n_fail++;
      $display("FAIL bb_load_bus: got req=%b we=%b addr=%h mask=%b exp 1 0 00000024 0000",
               dm_req, dm_we, dm_addr, dm_mask);
    end
    dm_rdata = mem[dm_addr[5:2]];
    dm_ack   = 1'b1;
    tick();
    dm_ack = 1'b0;
    n_checks++;
    if ({rsp, lu_data, lu_size} !== {1'b1, 32'hDEAD_BEEF, 2'b10}) begin
      n_fail++;
      $display("FAIL bb_load_rsp: got rsp=%b data=%h size=%b exp 1 deadbeef 10",
               rsp, lu_data, lu_size);
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_size  = 2'b00;
    req_uns   = 1'b0;
    dm_rdata  = 32'h0;
    dm_ack    = 1'b0;
    for (int m = 0; m < 16; m++) mem[m] = 32'h0;
    #1;
    test_reset();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_byte_store();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
